// File: rtl/radius_stepper_pkg.sv
// radius_stepper_pkg
//    Shared types for the press-and-hold parameter stepper.
//    state_t : hold-tracking FSM states
//       ST_IDLE   - waiting for a fresh single-button press
//       ST_DELAY  - first step taken, waiting out the hold delay
//       ST_REPEAT - slow auto-repeat, counting repeat steps
//       ST_FAST   - accelerated auto-repeat with the large step
package radius_stepper_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DELAY  = 2'd1,
      ST_REPEAT = 2'd2,
      ST_FAST   = 2'd3
   } state_t;

endpackage

// File: rtl/sat_addsub.sv
// sat_addsub
//    Combinational saturating add/subtract of a step onto a value, clamped
//    to the range [min_val, max_val]. The arithmetic is done one bit wider
//    than WIDTH, so the result never wraps.
//
//    Ports:
//       value   in  WIDTH  current value
//       step    in  WIDTH  step magnitude
//       up      in  1      1 = add step, 0 = subtract step
//       min_val in  WIDTH  lower clamp
//       max_val in  WIDTH  upper clamp
//       result  out WIDTH  clamped next value
module sat_addsub #(
   parameter int unsigned WIDTH = 5
) (
   input  logic [WIDTH-1:0] value,
   input  logic [WIDTH-1:0] step,
   input  logic             up,
   input  logic [WIDTH-1:0] min_val,
   input  logic [WIDTH-1:0] max_val,
   output logic [WIDTH-1:0] result
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] min_plus_step;

   // Going down, compare value against min+step rather than computing
   // value-step, so that an underflow can never be mistaken for a large value.
   always_comb begin
      sum           = {1'b0, value} + {1'b0, step};
      min_plus_step = {1'b0, min_val} + {1'b0, step};
      result        = value;
      if (up) begin
         if (sum > {1'b0, max_val}) begin
            result = max_val;
         end else begin
            result = sum[WIDTH-1:0];
         end
      end else begin
         if ({1'b0, value} < min_plus_step) begin
            result = min_val;
         end else begin
            result = value - step;
         end
      end
   end

endmodule

// File: rtl/radius_stepper.sv
// radius_stepper
//    Saturating up/down parameter register driven by two held buttons. It
//    auto-repeats while a button is held and accelerates to FAST_STEP after
//    FAST_AFTER slow repeats. It also has a load-default pulse and status flags.
//
//    Ports:
//       clk         in  1      system clock, rising edge
//       rst         in  1      asynchronous active-high reset
//       increase    in  1      debounced increase button (level)
//       decrease    in  1      debounced decrease button (level)
//       set_default in  1      single-cycle pulse, load INIT
//       value       out WIDTH  current parameter value (registered)
//       at_min      out 1      value == MIN (registered)
//       at_max      out 1      value == MAX (registered)
//       changed     out 1      pulse, value changed on this edge
module radius_stepper
   import radius_stepper_pkg::*;
#(
   parameter int unsigned WIDTH         = 5,
   parameter int unsigned MIN           = 1,
   parameter int unsigned MAX           = 10,
   parameter int unsigned INIT          = 4,
   parameter int unsigned HOLD_DELAY    = 4,
   parameter int unsigned REPEAT_PERIOD = 2,
   parameter int unsigned FAST_AFTER    = 3,
   parameter int unsigned FAST_STEP     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             increase,
   input  logic             decrease,
   input  logic             set_default,
   output logic [WIDTH-1:0] value,
   output logic             at_min,
   output logic             at_max,
   output logic             changed
);

   // One shared timer serves both the hold delay and the repeat period, so
   // it is sized for whichever of the two is longer.
   localparam int unsigned TMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
   localparam int unsigned RW   = (FAST_AFTER > 0) ? $clog2(FAST_AFTER + 1) : 1;

   localparam logic [TW-1:0]    HOLD_LAST   = TW'(HOLD_DELAY - 1);
   localparam logic [TW-1:0]    REP_LAST    = TW'(REPEAT_PERIOD - 1);
   localparam logic [RW-1:0]    FAST_COUNT  = RW'(FAST_AFTER);
   localparam logic [WIDTH-1:0] MIN_V       = WIDTH'(MIN);
   localparam logic [WIDTH-1:0] MAX_V       = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] INIT_V      = WIDTH'(INIT);
   localparam logic [WIDTH-1:0] FAST_V      = WIDTH'(FAST_STEP);
   localparam logic             AT_MIN_INIT = (INIT == MIN);
   localparam logic             AT_MAX_INIT = (INIT == MAX);

   state_t           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic [RW-1:0]    rep_q, rep_d;
   logic             dir_q, dir_d;
   logic [1:0]       prev_btn_q, prev_btn_d;
   logic [WIDTH-1:0] value_q, value_d;
   logic             at_min_q, at_min_d;
   logic             at_max_q, at_max_d;
   logic             changed_q, changed_d;

   logic             new_press;
   logic             hold_ok;
   logic             do_step;
   logic             fast_step;
   logic             step_up;
   logic [WIDTH-1:0] step_size;
   logic [WIDTH-1:0] sat_value;

   sat_addsub #(
      .WIDTH(WIDTH)
   ) u_sat (
      .value  (value_q),
      .step   (step_size),
      .up     (step_up),
      .min_val(MIN_V),
      .max_val(MAX_V),
      .result (sat_value)
   );

   // Next-state logic for the hold FSM. A fresh press needs the previous
   // button sample to be fully released. Any deviation from the latched
   // direction (release, both pressed, reversal) drops back to idle
   // without a step. set_default overrides everything on the same edge.
   always_comb begin
      prev_btn_d = {increase, decrease};
      new_press  = (increase ^ decrease) && (prev_btn_q == 2'b00);
      hold_ok    = dir_q ? (prev_btn_d == 2'b10) : (prev_btn_d == 2'b01);

      state_d    = state_q;
      timer_d    = timer_q;
      rep_d      = rep_q;
      dir_d      = dir_q;
      do_step    = 1'b0;
      fast_step  = 1'b0;
      step_up    = dir_q;

      case (state_q)
         ST_IDLE: begin
            if (new_press) begin
               dir_d   = increase;
               step_up = increase;
               do_step = 1'b1;
               timer_d = '0;
               state_d = ST_DELAY;
            end
         end
         ST_DELAY: begin
            if (!hold_ok) begin
               state_d = ST_IDLE;
               timer_d = '0;
               rep_d   = '0;
            end else if (timer_q == HOLD_LAST) begin
               do_step = 1'b1;
               timer_d = '0;
               rep_d   = '0;
               state_d = ST_REPEAT;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_REPEAT: begin
            if (!hold_ok) begin
               state_d = ST_IDLE;
               timer_d = '0;
               rep_d   = '0;
            end else if (timer_q == REP_LAST) begin
               do_step = 1'b1;
               timer_d = '0;
               rep_d   = rep_q + 1'b1;
               if (rep_q + 1'b1 == FAST_COUNT) begin
                  state_d = ST_FAST;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         ST_FAST: begin
            if (!hold_ok) begin
               state_d = ST_IDLE;
               timer_d = '0;
               rep_d   = '0;
            end else if (timer_q == REP_LAST) begin
               do_step   = 1'b1;
               fast_step = 1'b1;
               timer_d   = '0;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            timer_d = '0;
            rep_d   = '0;
         end
      endcase

      if (set_default) begin
         state_d = ST_IDLE;
         timer_d = '0;
         rep_d   = '0;
      end

      step_size = fast_step ? FAST_V : WIDTH'(1);

      if (set_default) begin
         value_d = INIT_V;
      end else if (do_step) begin
         value_d = sat_value;
      end else begin
         value_d = value_q;
      end

      changed_d = (value_d != value_q);
      at_min_d  = (value_d == MIN_V);
      at_max_d  = (value_d == MAX_V);
   end

   // State registers. The flags are registered alongside value, so they
   // always describe the value currently on the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         timer_q    <= '0;
         rep_q      <= '0;
         dir_q      <= 1'b0;
         prev_btn_q <= 2'b00;
         value_q    <= INIT_V;
         at_min_q   <= AT_MIN_INIT;
         at_max_q   <= AT_MAX_INIT;
         changed_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         rep_q      <= rep_d;
         dir_q      <= dir_d;
         prev_btn_q <= prev_btn_d;
         value_q    <= value_d;
         at_min_q   <= at_min_d;
         at_max_q   <= at_max_d;
         changed_q  <= changed_d;
      end
   end

   assign value   = value_q;
   assign at_min  = at_min_q;
   assign at_max  = at_max_q;
   assign changed = changed_q;

endmodule

// File: tb/tb_radius_stepper.sv
// tb_radius_stepper
//    Directed bench for radius_stepper with MIN=2, MAX=20, INIT=4. Inputs
//    change and outputs are sampled on the falling edge, so every rising
//    edge sees settled inputs.
module tb_radius_stepper;

   localparam int WIDTH = 5;

   logic             clk = 1'b0;
   logic             rst;
   logic             increase;
   logic             decrease;
   logic             set_default;
   logic [WIDTH-1:0] value;
   logic             at_min;
   logic             at_max;
   logic             changed;

   int checkCount = 0;
   int errCount   = 0;

   radius_stepper #(
      .WIDTH        (5),
      .MIN          (2),
      .MAX          (20),
      .INIT         (4),
      .HOLD_DELAY   (4),
      .REPEAT_PERIOD(2),
      .FAST_AFTER   (3),
      .FAST_STEP    (3)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .increase   (increase),
      .decrease   (decrease),
      .set_default(set_default),
      .value      (value),
      .at_min     (at_min),
      .at_max     (at_max),
      .changed    (changed)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Advance one rising edge and return on the following falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Drive the three button/pulse inputs together
   task automatic applyStimulus(input logic inc, input logic dec, input logic sd);
      increase    = inc;
      decrease    = dec;
      set_default = sd;
   endtask

   // Single comparison point: counts and reports mismatches
   task automatic checkOutput(input string tag, input int actual, input int expected);
      checkCount++;
      if (actual != expected) begin
         errCount++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
      end
   endtask

   // Hand-computed expectations for a hold starting at edge k (index = cycles after k)
   int expUp[24] = '{5, 5, 5, 5, 6, 6, 7, 7, 8, 8, 9, 9,
                     12, 12, 15, 15, 18, 18, 20, 20, 20, 20, 20, 20};
   int expDown[21] = '{19, 19, 19, 19, 18, 18, 17, 17, 16, 16, 15, 15,
                       12, 12, 9, 9, 6, 6, 3, 3, 2};

   // Main directed sequence
   initial begin
      int prevVal;
      int expVal;

      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      checkOutput("rst_value", value, 4);
      checkOutput("rst_at_min", at_min, 0);
      checkOutput("rst_at_max", at_max, 0);
      checkOutput("rst_changed", changed, 0);
      rst = 1'b0;
      tick();
      checkOutput("idle_value", value, 4);

      $display("[TB] single increase tap");
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("tap_value", value, 5);
      checkOutput("tap_changed", changed, 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("tap_hold_value", value, 5);
         checkOutput("tap_hold_changed", changed, 0);
      end

      $display("[TB] set_default then held increase");
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("def_value", value, 4);
      checkOutput("def_changed", changed, 1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      prevVal = 4;
      for (int c = 0; c < 24; c++) begin
         tick();
         checkOutput("up_value", value, expUp[c]);
         checkOutput("up_changed", changed, (expUp[c] != prevVal) ? 1 : 0);
         checkOutput("up_at_max", at_max, (expUp[c] == 20) ? 1 : 0);
         prevVal = expUp[c];
      end

      $display("[TB] held decrease to saturation");
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("release_value", value, 20);
      applyStimulus(1'b0, 1'b1, 1'b0);
      prevVal = 20;
      for (int c = 0; c < 40; c++) begin
         tick();
         expVal = (c <= 20) ? expDown[c] : 2;
         checkOutput("down_value", value, expVal);
         checkOutput("down_changed", changed, (expVal != prevVal) ? 1 : 0);
         checkOutput("down_at_min", at_min, (expVal == 2) ? 1 : 0);
         prevVal = expVal;
      end

      $display("[TB] both pressed, then one released");
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 1'b1);
      tick();
      checkOutput("def2_value", value, 4);
      applyStimulus(1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checkOutput("both_value", value, 4);
      end
      applyStimulus(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         tick();
         checkOutput("one_left_value", value, 4);
         checkOutput("one_left_changed", changed, 0);
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("dec_tap_value", value, 3);
      checkOutput("dec_tap_changed", changed, 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("dec_tap_after", value, 3);

      $display("[TB] set_default during FAST hold");
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int c = 0; c < 13; c++) begin
         tick();
      end
      checkOutput("fast_value", value, 11);
      applyStimulus(1'b1, 1'b0, 1'b1);
      tick();
      checkOutput("fast_def_value", value, 4);
      checkOutput("fast_def_changed", changed, 1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         tick();
         checkOutput("post_def_value", value, 4);
         checkOutput("post_def_changed", changed, 0);
      end

      $display("[TB] asynchronous reset mid-hold");
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0, 1'b0);
      tick();
      checkOutput("pre_rst_value", value, 5);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_rst_value", value, 4);
      checkOutput("async_rst_changed", changed, 0);
      checkOutput("async_rst_at_min", at_min, 0);
      checkOutput("async_rst_at_max", at_max, 0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      checkOutput("held_thru_rst_value", value, 5);
      checkOutput("held_thru_rst_changed", changed, 1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      tick();

      $display("Result: errors=%0d of %0d checks", errCount, checkCount);
      $finish;
   end

endmodule
